rtc_bus_ctrl: RTL and testbench
===============================

RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 The block SHALL have parameter T_STEP, default 4, giving clock cycles per bus sub-phase (legal 1..15).
REQ-002 The block SHALL have parameter T_GAP, default 4, giving idle recovery cycles after each transaction (legal 1..15).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  transaction request; sampled only in IDLE.
REQ-006 rw  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  8  RTC register address; sampled with req.
REQ-008 wdata  input  8  write data; sampled with req.
REQ-009 busy  output  1  high while a transaction is in progress.
REQ-010 done  output  1  one-cycle pulse at transaction end.
REQ-011 rdata  output  8  last byte read from the RTC.
REQ-012 rtc_cs_n, rtc_rd_n, rtc_wr_n  output  1 each  active-low chip select, read strobe, write strobe.
REQ-013 rtc_ad  output  1  A/D select: 0 = address phase, 1 = data phase.
REQ-014 ad_out  output  8  byte driven onto the multiplexed bus; ad_oe  output  1  tristate enable for ad_out; ad_in  input  8  bus readback.

Function
REQ-015 All outputs SHALL be registered, with no combinational path from input to output.
REQ-016 States SHALL be IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, GAP; every non-IDLE state except GAP SHALL last exactly T_STEP cycles, and GAP SHALL last exactly T_GAP cycles, timed by a 4-bit down-counter.
REQ-017 In IDLE with req=1, the block SHALL latch rw, addr and wdata on that edge and enter A_SET; req SHALL be ignored in every other state.
REQ-018 Sequence: IDLE -> A_SET -> A_STB -> A_HLD -> D_SET -> D_STB -> D_HLD -> GAP -> IDLE, with no skipped states.
REQ-019 Bus signals in A_SET, A_STB and A_HLD: rtc_cs_n=0, rtc_ad=0, ad_oe=1, ad_out=addr; rtc_wr_n=0 in A_STB only; rtc_rd_n=1.
REQ-020 Bus signals in D_SET, D_STB and D_HLD: rtc_cs_n=0, rtc_ad=1.
REQ-021 Write data phase: ad_oe=1, ad_out=wdata; rtc_wr_n=0 in D_STB only.
REQ-022 Read data phase: ad_oe=0; rtc_rd_n=0 in D_STB only.
REQ-023 On a read, rdata SHALL capture ad_in on the final clock of D_STB and hold it until the next read capture; writes SHALL NOT alter rdata.
REQ-024 Bus signals in IDLE and GAP: rtc_cs_n=1, rtc_rd_n=1, rtc_wr_n=1, ad_oe=0, rtc_ad=1, ad_out=0.
REQ-025 busy SHALL be 1 in every non-IDLE state; for each accepted request it SHALL stay high for exactly 6*T_STEP+T_GAP cycles (28 at defaults).
REQ-026 done SHALL be 1 only during the last GAP cycle, and req sampled high on the following edge SHALL start a new transaction (back-to-back operation).
REQ-027 rtc_rd_n and rtc_wr_n SHALL never be low simultaneously, and ad_oe SHALL never be 1 while rtc_rd_n=0.

Reset
REQ-028 reset SHALL force the state to IDLE immediately, even mid-transaction, with no done pulse, and the aborted transaction SHALL not be resumed.
REQ-029 Reset values: busy=0, done=0, rdata=8'h00, rtc_cs_n=1, rtc_rd_n=1, rtc_wr_n=1, rtc_ad=1, ad_out=8'h00, ad_oe=0, counter=0.

Verification
REQ-030 Write at defaults, req=1, rw=1, addr=8'h26, wdata=8'h17 -> ad_out=26 with rtc_ad=0 for 12 cycles; rtc_wr_n low for 4 cycles mid address phase; then ad_out=17 with rtc_ad=1, rtc_wr_n low 4 cycles; done on cycle 28.
REQ-031 Read, rw=0, addr=8'h24, ad_in=8'h59 during D_STB -> ad_oe=0 and rtc_rd_n low 4 cycles in data phase; rdata=8'h59 after D_STB; done on cycle 28.
REQ-032 Request while busy, req pulsed on cycle 10 of a transaction -> ignored; exactly one done pulse; bus shows only the original addr and data.
REQ-033 Back-to-back, req held high across done -> second transaction's A_SET starts on the cycle after done; busy low for 0 cycles between the two transactions.
REQ-034 Mid-operation reset, reset asserted in D_STB of a write -> the same cycle asynchronously gives rtc_wr_n=1, rtc_cs_n=1, ad_oe=0, busy=0; no done pulse; rdata unchanged.
REQ-035 Parameters T_STEP=1, T_GAP=1 -> busy high for 7 cycles, and every strobe low for exactly 1 cycle.

Source files
------------

// File: rtl/rtc_bus_ctrl_if.sv
// rtl/rtc_bus_ctrl_if.sv - host request and RTC multiplexed bus signals for rtc_bus_ctrl
interface rtc_bus_ctrl_if;
    logic       req;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       rtc_cs_n;
    logic       rtc_rd_n;
    logic       rtc_wr_n;
    logic       rtc_ad;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport slave (
        input  req, rw, addr, wdata, ad_in,
        output busy, done, rdata, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_out, ad_oe
    );

    modport master (
        output req, rw, addr, wdata, ad_in,
        input  busy, done, rdata, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - multiplexed address/data RTC bus sequencer with timed sub-phases
module rtc_bus_ctrl #(
    parameter int T_STEP = 4,
    parameter int T_GAP  = 4
) (
    input  logic          clk,
    input  logic          reset,
    rtc_bus_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_A_SET, S_A_STB, S_A_HLD, S_D_SET, S_D_STB, S_D_HLD, S_GAP
    } state_t;

    localparam logic [3:0] STEP_LD = 4'(T_STEP - 1);
    localparam logic [3:0] GAP_LD  = 4'(T_GAP - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt;
    logic       w_accept;
    logic       r_rw;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       w_rw;
    logic [7:0] w_addr;
    logic [7:0] w_wdata;

    // The end of GAP behaves like IDLE so a held req chains without a dead cycle.
    always_comb begin
        w_next   = r_state;
        w_cnt    = r_cnt;
        w_accept = 1'b0;
        if (r_state == S_IDLE || (r_state == S_GAP && r_cnt == 4'd0)) begin
            if (bus.req) begin
                w_next   = S_A_SET;
                w_cnt    = STEP_LD;
                w_accept = 1'b1;
            end else begin
                w_next = S_IDLE;
                w_cnt  = 4'd0;
            end
        end else if (r_cnt != 4'd0) begin
            w_cnt = r_cnt - 4'd1;
        end else begin
            w_cnt = STEP_LD;
            case (r_state)
                S_A_SET: w_next = S_A_STB;
                S_A_STB: w_next = S_A_HLD;
                S_A_HLD: w_next = S_D_SET;
                S_D_SET: w_next = S_D_STB;
                S_D_STB: w_next = S_D_HLD;
                S_D_HLD: begin
                    w_next = S_GAP;
                    w_cnt  = GAP_LD;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign w_rw    = w_accept ? bus.rw    : r_rw;
    assign w_addr  = w_accept ? bus.addr  : r_addr;
    assign w_wdata = w_accept ? bus.wdata : r_wdata;

    // Outputs are decoded from the next state so every pin is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_rw         <= 1'b0;
            r_addr       <= 8'h00;
            r_wdata      <= 8'h00;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rdata    <= 8'h00;
            bus.rtc_cs_n <= 1'b1;
            bus.rtc_rd_n <= 1'b1;
            bus.rtc_wr_n <= 1'b1;
            bus.rtc_ad   <= 1'b1;
            bus.ad_out   <= 8'h00;
            bus.ad_oe    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt;
            r_rw     <= w_rw;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            bus.busy <= (w_next != S_IDLE);
            bus.done <= (w_next == S_GAP) && (w_cnt == 4'd0);
            if (r_state == S_D_STB && r_cnt == 4'd0 && !r_rw) begin
                bus.rdata <= bus.ad_in;
            end
            bus.rtc_cs_n <= 1'b1;
            bus.rtc_rd_n <= 1'b1;
            bus.rtc_wr_n <= 1'b1;
            bus.rtc_ad   <= 1'b1;
            bus.ad_out   <= 8'h00;
            bus.ad_oe    <= 1'b0;
            case (w_next)
                S_A_SET, S_A_STB, S_A_HLD: begin
                    bus.rtc_cs_n <= 1'b0;
                    bus.rtc_ad   <= 1'b0;
                    bus.ad_oe    <= 1'b1;
                    bus.ad_out   <= w_addr;
                    bus.rtc_wr_n <= (w_next != S_A_STB);
                end
                S_D_SET, S_D_STB, S_D_HLD: begin
                    bus.rtc_cs_n <= 1'b0;
                    bus.ad_oe    <= w_rw;
                    bus.ad_out   <= w_rw ? w_wdata : 8'h00;
                    bus.rtc_wr_n <= !(w_rw && w_next == S_D_STB);
                    bus.rtc_rd_n <= !(!w_rw && w_next == S_D_STB);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb/tb_rtc_bus_ctrl.sv - randomized timeline-model bench for rtc_bus_ctrl
module tb_rtc_bus_ctrl;
    localparam int TS = 4;
    localparam int TG = 4;
    localparam int N  = 6 * TS + TG;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] exp_rdata = 8'h00;

    rtc_bus_ctrl_if b ();
    rtc_bus_ctrl_if b1 ();

    rtc_bus_ctrl #(.T_STEP(TS), .T_GAP(TG)) dut (.clk(clk), .reset(reset), .bus(b));
    rtc_bus_ctrl #(.T_STEP(1), .T_GAP(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    // Expected pins {busy,done,cs_n,rd_n,wr_n,ad,oe,out,rdata} at cycle k after acceptance.
    function automatic logic [22:0] model(input int k, input int t, input int g, input logic rw,
                                          input logic [7:0] a, input logic [7:0] wd, input logic [7:0] rd);
        int   n  = 6 * t + g;
        int   ph = k / t;
        logic strobe;
        logic busy_e, done_e, cs_e, rdn_e, wrn_e, ad_e, oe_e;
        logic [7:0] out_e;
        busy_e = (k < n);
        done_e = (k == n - 1);
        cs_e = 1'b1; rdn_e = 1'b1; wrn_e = 1'b1; ad_e = 1'b1; oe_e = 1'b0; out_e = 8'h00;
        if (k < 6 * t) begin
            strobe = ((ph % 3) == 1);
            cs_e   = 1'b0;
            if (ph < 3) begin
                ad_e = 1'b0; oe_e = 1'b1; out_e = a; wrn_e = !strobe;
            end else begin
                oe_e  = rw;
                out_e = rw ? wd : 8'h00;
                wrn_e = !(rw && strobe);
                rdn_e = !(!rw && strobe);
            end
        end
        return {busy_e, done_e, cs_e, rdn_e, wrn_e, ad_e, oe_e, out_e, rd};
    endfunction

    task automatic run_txn(input logic rw, input logic [7:0] a, input logic [7:0] wd, input logic [7:0] rdv,
                           input int pulse_k, input bit started, input bit chain,
                           input logic nrw, input logic [7:0] na, input logic [7:0] nwd);
        logic [22:0] obs, exp_v;
        logic [7:0]  rd_e;
        if (!started) begin
            @(negedge clk);
            b.req = 1'b1; b.rw = rw; b.addr = a; b.wdata = wd;
        end
        for (int k = 0; k <= (chain ? N - 1 : N); k++) begin
            @(negedge clk);
            rd_e  = (!rw && k >= 5 * TS) ? rdv : exp_rdata;
            exp_v = model(k, TS, TG, rw, a, wd, rd_e);
            obs   = {b.busy, b.done, b.rtc_cs_n, b.rtc_rd_n, b.rtc_wr_n, b.rtc_ad, b.ad_oe, b.ad_out, b.rdata};
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL txn rw=%0b addr=%h cyc %0d: got %h want %h", rw, a, k, obs, exp_v);
            end
            b.req = 1'b0;
            if (k == pulse_k) begin
                b.req = 1'b1; b.rw = ~rw; b.addr = ~a; b.wdata = ~wd;
            end
            if (chain && k == N - 1) begin
                b.req = 1'b1; b.rw = nrw; b.addr = na; b.wdata = nwd;
            end
            b.ad_in = (k >= 4 * TS && k < 5 * TS) ? rdv : ~rdv;
        end
        if (!rw) exp_rdata = rdv;
    endtask

    task automatic test_reset();
        logic [22:0] obs;
        repeat (2) @(negedge clk);
        obs = {b.busy, b.done, b.rtc_cs_n, b.rtc_rd_n, b.rtc_wr_n, b.rtc_ad, b.ad_oe, b.ad_out, b.rdata};
        n_checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00}) begin
            n_errors++;
            $display("FAIL reset_values: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00});
        end
        reset = 1'b0;
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        @(negedge clk);
        b.req = 1'b1; b.rw = 1'b1; b.addr = 8'h3C; b.wdata = 8'hA5;
        for (int k = 0; k <= 4 * TS + 1; k++) begin
            @(negedge clk);
            b.req = 1'b0;
        end
        n_checks++;
        if (b.rtc_wr_n !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_pre_wr_n: got %b want 0", b.rtc_wr_n);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({b.rtc_wr_n, b.rtc_cs_n, b.ad_oe, b.busy, b.done, b.rdata} !== {5'b11000, exp_rdata}) begin
            n_errors++;
            $display("FAIL mid_reset_async: got %h want %h",
                     {b.rtc_wr_n, b.rtc_cs_n, b.ad_oe, b.busy, b.done, b.rdata}, {5'b11000, exp_rdata});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < N + 4; k++) begin
            @(negedge clk);
            if (b.busy !== 1'b0 || b.done !== 1'b0 || b.rtc_cs_n !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL mid_reset_no_resume: active cycles %0d want 0", bad);
        end
    endtask

    task automatic test_directed();
        run_txn(1'b1, 8'h26, 8'h17, 8'h00, -1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        run_txn(1'b0, 8'h24, 8'h00, 8'h59, -1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        run_txn(1'b1, 8'h11, 8'h22, 8'h00, 10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic rw = 1'($urandom);
            int   pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N - 3)) : -1;
            run_txn(rw, 8'($urandom), 8'($urandom), 8'($urandom), pk, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        logic       rw0 = 1'($urandom), rw1 = 1'($urandom), rw2 = 1'($urandom);
        logic [7:0] a0 = 8'($urandom), a1 = 8'($urandom), a2 = 8'($urandom);
        logic [7:0] d0 = 8'($urandom), d1 = 8'($urandom), d2 = 8'($urandom);
        run_txn(rw0, a0, d0, 8'($urandom), -1, 1'b0, 1'b1, rw1, a1, d1);
        run_txn(rw1, a1, d1, 8'($urandom), -1, 1'b1, 1'b1, rw2, a2, d2);
        run_txn(rw2, a2, d2, 8'($urandom), -1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_fast(input logic rw);
        int busy_n = 0, done_n = 0, wr_n = 0, rd_n = 0, runs = 0;
        logic pw = 1'b1, pr = 1'b1;
        logic [7:0] v = 8'($urandom);
        @(negedge clk);
        b1.req = 1'b1; b1.rw = rw; b1.addr = 8'($urandom); b1.wdata = 8'($urandom); b1.ad_in = v;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            b1.req = 1'b0;
            if (b1.busy) busy_n++;
            if (b1.done) done_n++;
            if (!b1.rtc_wr_n) wr_n++;
            if (!b1.rtc_rd_n) rd_n++;
            if ((!b1.rtc_wr_n && !pw) || (!b1.rtc_rd_n && !pr)) runs++;
            pw = b1.rtc_wr_n;
            pr = b1.rtc_rd_n;
        end
        n_checks++;
        if (busy_n != 7) begin n_errors++; $display("FAIL fast_busy rw=%0b: got %0d want 7", rw, busy_n); end
        n_checks++;
        if (done_n != 1) begin n_errors++; $display("FAIL fast_done rw=%0b: got %0d want 1", rw, done_n); end
        n_checks++;
        if (wr_n != (rw ? 2 : 1) || rd_n != (rw ? 0 : 1) || runs != 0) begin
            n_errors++;
            $display("FAIL fast_strobes rw=%0b: wr %0d rd %0d runs %0d want wr %0d rd %0d runs 0",
                     rw, wr_n, rd_n, runs, rw ? 2 : 1, rw ? 0 : 1);
        end
        if (!rw) begin
            n_checks++;
            if (b1.rdata !== v) begin n_errors++; $display("FAIL fast_rdata: got %h want %h", b1.rdata, v); end
        end
    endtask

    initial begin
        reset = 1'b1;
        b.req = 1'b0; b.rw = 1'b0; b.addr = 8'h00; b.wdata = 8'h00; b.ad_in = 8'h00;
        b1.req = 1'b0; b1.rw = 1'b0; b1.addr = 8'h00; b1.wdata = 8'h00; b1.ad_in = 8'h00;
        test_reset();
        test_mid_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_fast(1'b1);
        test_fast(1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
